// File: rtl/regfile_writeback_pkg.sv
// Shared constants and types for the register-file writeback stage.
//   DATA_WIDTH     : result data width
//   REG_ADDR_WIDTH : register index width
//   NUM_REGS       : number of architectural registers
//   wb_src_e       : which source owns the write port this cycle
//   wb_req_t       : writeback request payload {reg_idx, data}
package regfile_writeback_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 4;
    localparam int unsigned NUM_REGS       = 16;

    typedef enum logic [1:0] {
        SRC_NONE       = 2'd0,
        SRC_ALU        = 2'd1,
        SRC_MEM_FIFO   = 2'd2,
        SRC_MEM_BYPASS = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] reg_idx;
        logic [DATA_WIDTH-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO buffering memory results behind the ALU.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   i_push      : write i_data (ignored when full)
//   i_data      : entry to write
//   i_pop       : drop head entry (ignored when empty); push+pop same cycle legal
//   o_head      : oldest entry
//   o_count     : occupancy, 0..DEPTH
//   o_full      : o_count == DEPTH
//   o_empty     : o_count == 0
module wb_result_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  wb_req_t                  i_data,
    input  logic                     i_pop,
    output wb_req_t                  o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_req_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port feeder merging ALU and load results, with a
// pending-load scoreboard for decode RAW hazard detection.
// Optional feature macro: REGFILE_WB_ZERO_REG_EN (register 0 is hard-wired:
// its commits are dropped, it is never pending, never hazards, never WAW).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   alu_valid/alu_reg/alu_data    : single-cycle ALU result (cannot stall)
//   mem_valid/mem_ready/mem_reg/mem_data : load result with backpressure
//   issue_valid/issue_reg         : load issued, marks destination pending
//   query_reg_a/b, hazard_a/b     : decode read addresses and pending flags
//   wr_en/wr_reg/wr_data          : registered register-file write port
//   fifo_count                    : memory result buffer occupancy
//   waw_err                       : pulse when ALU writes a load-pending register
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [REG_ADDR_WIDTH-1:0]     alu_reg,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [REG_ADDR_WIDTH-1:0]     mem_reg,
    input  logic [DATA_WIDTH-1:0]         mem_data,
    input  logic                          issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0]     issue_reg,
    input  logic [REG_ADDR_WIDTH-1:0]     query_reg_a,
    input  logic [REG_ADDR_WIDTH-1:0]     query_reg_b,
    output logic                          hazard_a,
    output logic                          hazard_b,
    output logic                          wr_en,
    output logic [REG_ADDR_WIDTH-1:0]     wr_reg,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          waw_err
);

    wb_req_t                    w_head;
    wb_req_t                    w_mem_req;
    wb_req_t                    w_commit;
    wb_src_e                    w_src;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic                       w_mem_accept;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_commit_en;
    logic                       w_mem_commit;
    logic                       w_waw;
    logic [NUM_REGS-1:0]        w_set;
    logic [NUM_REGS-1:0]        w_clr;

    logic                       r_wr_en;
    logic [REG_ADDR_WIDTH-1:0]  r_wr_reg;
    logic [DATA_WIDTH-1:0]      r_wr_data;
    logic                       r_waw_err;
    logic [NUM_REGS-1:0]        r_pending;

    assign mem_ready    = ~w_fifo_full;
    assign w_mem_accept = mem_valid && mem_ready;
    assign w_mem_req    = '{reg_idx: mem_reg, data: mem_data};

    wb_result_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_mem_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Write-port arbitration: ALU, then buffered loads, then load bypass.
    always_comb begin
        w_src    = SRC_NONE;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_commit = '0;
        if (alu_valid) begin
            w_src    = SRC_ALU;
            w_commit = '{reg_idx: alu_reg, data: alu_data};
            w_push   = w_mem_accept;
        end else if (!w_fifo_empty) begin
            w_src    = SRC_MEM_FIFO;
            w_commit = w_head;
            w_pop    = 1'b1;
            w_push   = w_mem_accept;
        end else if (w_mem_accept) begin
            w_src    = SRC_MEM_BYPASS;
            w_commit = w_mem_req;
        end
    end

    // Commit qualification and scoreboard set/clear masks.
    always_comb begin
        w_commit_en  = (w_src != SRC_NONE);
        w_mem_commit = (w_src == SRC_MEM_FIFO) || (w_src == SRC_MEM_BYPASS);
        w_waw        = (w_src == SRC_ALU) && r_pending[alu_reg];
        w_set        = issue_valid ? (NUM_REGS'(1) << issue_reg) : '0;
        w_clr        = w_mem_commit ? (NUM_REGS'(1) << w_commit.reg_idx) : '0;
`ifdef REGFILE_WB_ZERO_REG_EN
        // Register 0 commits still consume the FIFO entry; only the write is dropped.
        if (w_commit.reg_idx == '0) begin
            w_commit_en = 1'b0;
        end
        if (alu_reg == '0) begin
            w_waw = 1'b0;
        end
        w_set[0] = 1'b0;
`endif
    end

    // Hazards read registered pending bits only; same-cycle issues appear next cycle.
    always_comb begin
        hazard_a = r_pending[query_reg_a];
        hazard_b = r_pending[query_reg_b];
`ifdef REGFILE_WB_ZERO_REG_EN
        if (query_reg_a == '0) begin
            hazard_a = 1'b0;
        end
        if (query_reg_b == '0) begin
            hazard_b = 1'b0;
        end
`endif
    end

    // Registered write port, WAW pulse and scoreboard (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_reg  <= '0;
            r_wr_data <= '0;
            r_waw_err <= 1'b0;
            r_pending <= '0;
        end else begin
            r_wr_en   <= w_commit_en;
            r_waw_err <= w_waw;
            if (w_commit_en) begin
                r_wr_reg  <= w_commit.reg_idx;
                r_wr_data <= w_commit.data;
            end
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_reg  = r_wr_reg;
    assign wr_data = r_wr_data;
    assign waw_err = r_waw_err;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_regfile_writeback;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_reg;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_reg;
    logic [31:0] mem_data;
    logic        issue_valid;
    logic [3:0]  issue_reg;
    logic [3:0]  query_reg_a;
    logic [3:0]  query_reg_b;
    logic        hazard_a;
    logic        hazard_b;
    logic        wr_en;
    logic [3:0]  wr_reg;
    logic [31:0] wr_data;
    logic [2:0]  fifo_count;
    logic        waw_err;

    always #5 clk = ~clk;

    regfile_writeback #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_reg     (alu_reg),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_reg     (mem_reg),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .query_reg_a (query_reg_a),
        .query_reg_b (query_reg_b),
        .hazard_a    (hazard_a),
        .hazard_b    (hazard_b),
        .wr_en       (wr_en),
        .wr_reg      (wr_reg),
        .wr_data     (wr_data),
        .fifo_count  (fifo_count),
        .waw_err     (waw_err)
    );

    typedef struct {
        logic [3:0]  r;
        logic [31:0] d;
    } req_t;

    req_t        q[$];
    bit   [15:0] pend;
    logic        exp_en;
    logic [3:0]  exp_reg;
    logic [31:0] exp_data;
    logic        exp_waw;
    bit          started = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a plain queue, the scoreboard a bit array.
    always @(posedge clk) begin : model
        req_t c;
        bit   acc;
        bit   en;
        bit   memc;
        c = '{4'd0, 32'd0};
        if (rst) begin
            q.delete();
            pend     = '0;
            exp_en   = 1'b0;
            exp_reg  = '0;
            exp_data = '0;
            exp_waw  = 1'b0;
            started  = 1'b1;
        end else begin
            acc     = mem_valid && (q.size() < DEPTH);
            en      = 1'b0;
            memc    = 1'b0;
            exp_waw = 1'b0;
            if (alu_valid) begin
                c       = '{alu_reg, alu_data};
                en      = 1'b1;
                exp_waw = pend[alu_reg];
                if (acc) q.push_back('{mem_reg, mem_data});
            end else if (q.size() != 0) begin
                c    = q.pop_front();
                en   = 1'b1;
                memc = 1'b1;
                if (acc) q.push_back('{mem_reg, mem_data});
            end else if (acc) begin
                c    = '{mem_reg, mem_data};
                en   = 1'b1;
                memc = 1'b1;
            end
`ifdef REGFILE_WB_ZERO_REG_EN
            if (c.r == 4'd0) en = 1'b0;
            if (alu_valid && alu_reg == 4'd0) exp_waw = 1'b0;
`endif
            if (memc) pend[c.r] = 1'b0;
            if (issue_valid) begin
`ifdef REGFILE_WB_ZERO_REG_EN
                if (issue_reg != 4'd0) pend[issue_reg] = 1'b1;
`else
                pend[issue_reg] = 1'b1;
`endif
            end
            exp_en = en;
            if (en) begin
                exp_reg  = c.r;
                exp_data = c.d;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("m_wr_en",      32'(wr_en),      32'(exp_en));
            chk("m_wr_reg",     32'(wr_reg),     32'(exp_reg));
            chk("m_wr_data",    wr_data,         exp_data);
            chk("m_waw_err",    32'(waw_err),    32'(exp_waw));
            chk("m_fifo_count", 32'(fifo_count), 32'(q.size()));
            chk("m_mem_ready",  32'(mem_ready),  32'(q.size() != DEPTH));
            chk("m_hazard_a",   32'(hazard_a),   32'(pend[query_reg_a]));
            chk("m_hazard_b",   32'(hazard_b),   32'(pend[query_reg_b]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
        issue_valid = 1'b0;
    endtask

    initial begin
        int mi;
        bit accepted;
        rst = 1'b1;
        alu_reg = '0; alu_data = '0; mem_reg = '0; mem_data = '0;
        issue_reg = '0; query_reg_a = '0; query_reg_b = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(mem_ready), 32'd1);
        tick();
        chk("post_rst_ready", 32'(mem_ready), 32'd1);

        // ALU single write, one-cycle latency
        alu_valid = 1'b1; alu_reg = 4'd3; alu_data = 32'd30;
        tick();
        idle();
        chk("alu_wr_en", 32'(wr_en), 32'd1);
        chk("alu_wr_reg", 32'(wr_reg), 32'd3);
        chk("alu_wr_data", wr_data, 32'd30);
        tick();
        chk("alu_wr_en_drop", 32'(wr_en), 32'd0);

        // Memory bypass when FIFO empty
        mem_valid = 1'b1; mem_reg = 4'd5; mem_data = 32'h55;
        chk("bypass_ready", 32'(mem_ready), 32'd1);
        tick();
        idle();
        chk("bypass_wr_en", 32'(wr_en), 32'd1);
        chk("bypass_wr_reg", 32'(wr_reg), 32'd5);
        chk("bypass_wr_data", wr_data, 32'h55);
        chk("bypass_count", 32'(fifo_count), 32'd0);

        // Six ALU cycles while memory offers 1..6; then in-order drain
        mi = 1;
        for (int c = 0; c < 14; c++) begin
            alu_valid = (c < 6);
            alu_reg   = 4'd8;
            alu_data  = 32'(1000 + c);
            mem_valid = (mi <= 6);
            mem_reg   = 4'(mi);
            mem_data  = 32'(10 * mi);
            accepted  = mem_valid && mem_ready;
            tick();
            if (accepted) mi++;
            if (c == 3) begin
                chk("fill_count", 32'(fifo_count), 32'd4);
                chk("fill_ready", 32'(mem_ready), 32'd0);
            end
            if (c >= 6 && c < 12) begin
                chk("drain_wr_en", 32'(wr_en), 32'd1);
                chk("drain_wr_reg", 32'(wr_reg), 32'(c - 5));
                chk("drain_wr_data", wr_data, 32'(10 * (c - 5)));
            end
        end
        idle();

        // Scoreboard: issue, clear by commit, set-wins on same edge
        issue_valid = 1'b1; issue_reg = 4'd7; query_reg_a = 4'd7;
        chk("haz_same_cycle", 32'(hazard_a), 32'd0);
        tick();
        idle();
        chk("haz_set", 32'(hazard_a), 32'd1);
        mem_valid = 1'b1; mem_reg = 4'd7; mem_data = 32'h77;
        tick();
        idle();
        chk("haz_clr_wr_en", 32'(wr_en), 32'd1);
        chk("haz_clr_wr_reg", 32'(wr_reg), 32'd7);
        chk("haz_clr", 32'(hazard_a), 32'd0);
        issue_valid = 1'b1; issue_reg = 4'd7;
        tick();
        idle();
        chk("haz_reset", 32'(hazard_a), 32'd1);
        mem_valid = 1'b1; mem_reg = 4'd7; mem_data = 32'h78;
        issue_valid = 1'b1; issue_reg = 4'd7;
        tick();
        idle();
        chk("set_wins_wr_data", wr_data, 32'h78);
        chk("set_wins_haz", 32'(hazard_a), 32'd1);
        mem_valid = 1'b1; mem_reg = 4'd7; mem_data = 32'h79;
        tick();
        idle();
        chk("final_clr_haz", 32'(hazard_a), 32'd0);

        // WAW: ALU writes a load-pending register
        issue_valid = 1'b1; issue_reg = 4'd9;
        tick();
        idle();
        query_reg_b = 4'd9;
        alu_valid = 1'b1; alu_reg = 4'd9; alu_data = 32'd99;
        tick();
        idle();
        chk("waw_wr_data", wr_data, 32'd99);
        chk("waw_pulse", 32'(waw_err), 32'd1);
        chk("waw_haz", 32'(hazard_b), 32'd1);
        tick();
        chk("waw_pulse_end", 32'(waw_err), 32'd0);
        chk("waw_haz_hold", 32'(hazard_b), 32'd1);

        // Mixed traffic checked by the model only
        for (int c = 0; c < 300; c++) begin
            alu_valid   = ($urandom_range(0, 2) == 0);
            alu_reg     = 4'($urandom_range(0, 15));
            alu_data    = $urandom;
            mem_valid   = ($urandom_range(0, 1) == 0);
            mem_reg     = 4'($urandom_range(0, 15));
            mem_data    = $urandom;
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_reg   = 4'($urandom_range(0, 15));
            query_reg_a = 4'($urandom_range(0, 15));
            query_reg_b = 4'($urandom_range(0, 15));
            tick();
        end
        idle();
        for (int c = 0; c < 8; c++) tick();

        // Reset with a partly full buffer and pending loads
        query_reg_a = 4'd7; query_reg_b = 4'd9;
        for (int c = 0; c < 3; c++) begin
            alu_valid   = 1'b1; alu_reg = 4'd2; alu_data = 32'(c);
            mem_valid   = 1'b1; mem_reg = 4'(c + 10); mem_data = 32'(c + 100);
            issue_valid = (c < 2);
            issue_reg   = (c == 0) ? 4'd7 : 4'd9;
            tick();
        end
        idle();
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        chk("pre_rst_haz_a", 32'(hazard_a), 32'd1);
        chk("pre_rst_haz_b", 32'(hazard_b), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_ready", 32'(mem_ready), 32'd1);
        chk("mid_rst_haz_a", 32'(hazard_a), 32'd0);
        chk("mid_rst_haz_b", 32'(hazard_b), 32'd0);
        tick();
        chk("post_rst_wr_en", 32'(wr_en), 32'd0);

        // Register 0 write
        alu_valid = 1'b1; alu_reg = 4'd0; alu_data = 32'd5;
        tick();
        idle();
`ifdef REGFILE_WB_ZERO_REG_EN
        chk("reg0_wr_en", 32'(wr_en), 32'd0);
`else
        chk("reg0_wr_en", 32'(wr_en), 32'd1);
        chk("reg0_wr_data", wr_data, 32'd5);
`endif
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
